motor_ctrl: RTL and testbench
=============================

MOTOR_CTRL -- requirements
Module: motor_ctrl

Interface
REQ-001 SHALL have parameter N_CH, default 2: number of independent motor channels.
REQ-002 SHALL have parameter DUTY_W, default 7: duty width; MAX = 2^DUTY_W-1 PWM steps per period.
REQ-003 SHALL have parameter PRESCALE, default 1000: CLK_100MHz cycles per PWM step (>=1).
REQ-004 SHALL have parameter OC_HOLD, default 4: consecutive clear PWM periods required to leave FAULT (>=1).
REQ-005 SHALL have port CLK_100MHz, input, 1 bit: single system clock, rising edge.
REQ-006 SHALL have port RST_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port duty_cmd, input, N_CH*DUTY_W bits: channel i duty at [i*DUTY_W +: DUTY_W].
REQ-008 SHALL have port dir_cmd, input, N_CH bits: commanded direction (0 fwd, 1 rev).
REQ-009 SHALL have port enable, input, N_CH bits: channel run request.
REQ-010 SHALL have port oc_set, input, N_CH bits: overcurrent above trip level.
REQ-011 SHALL have port oc_clr, input, N_CH bits: current below release level.
REQ-012 SHALL have port motor_out, output, 2*N_CH bits: H-bridge drive; [2i] fwd leg, [2i+1] rev leg.
REQ-013 SHALL have port fault, output, N_CH bits: channel latched in FAULT.
REQ-014 SHALL have port period_start, output, 1 bit: one-cycle pulse at each PWM period boundary.

Function
REQ-015 SHALL run a shared prescaler 0..PRESCALE-1 and emit a one-cycle step tick on wrap.
REQ-016 SHALL run a shared PWM counter 0..MAX-1, advanced only on step tick; period_start pulses the cycle it wraps to 0.
REQ-017 SHALL keep a per-channel active duty duty_act; PWM level = (pwm_cnt < duty_act); duty_act=MAX gives 100%, 0 gives 0%.
REQ-018 SHALL change duty_act and current direction dir_act only at period_start (no mid-period glitches).
REQ-019 SHALL implement per-channel states IDLE, RAMP, RUN, RAMP_DOWN, DEAD, FAULT.
REQ-020 IDLE: duty_act=0; enable=1 at period_start -> latch dir_act=dir_cmd, go RAMP.
REQ-021 RAMP: duty_act += 1 per period until equal to duty_cmd, then RUN; if duty_cmd < duty_act, step down by 1 per period.
REQ-022 RUN: duty_act tracks duty_cmd at +/-1 per period (slew limit).
REQ-023 enable=0 or dir_cmd != dir_act in RAMP/RUN -> RAMP_DOWN; duty_act -= 1 per period to 0.
REQ-024 RAMP_DOWN reaching 0 -> DEAD for exactly one full PWM period with both legs low, then IDLE.
REQ-025 motor_out[2i] = PWM level when dir_act=0 else 0; motor_out[2i+1] = PWM level when dir_act=1 else 0; both legs never high together.
REQ-026 motor_out SHALL be registered: one CLK_100MHz cycle latency from counter/duty state to pin.
REQ-027 oc_set=1 in any state -> FAULT next cycle: duty_act=0, both legs low next cycle, fault=1; no period alignment.
REQ-028 FAULT exit: oc_clr=1 and oc_set=0 sampled at OC_HOLD consecutive period_starts -> IDLE, fault=0; any oc_set resets the count.
REQ-029 oc_set and oc_clr both high SHALL be treated as set (set wins).
REQ-030 Channels SHALL be fully independent; a fault on one SHALL not affect others.

Reset
REQ-031 RST_N=0 SHALL asynchronously force prescaler=0, pwm_cnt=0, all channels IDLE, duty_act=0, dir_act=0, hold counts=0.
REQ-032 During and after reset: motor_out=0, fault=0, period_start=0 until first wrap; reset mid-ramp or mid-fault SHALL discard all state.

Verification (PRESCALE=2, DUTY_W=4, MAX=15, OC_HOLD=2)
REQ-033 enable0=1, duty0=15, dir0=0 -> duty_act climbs 1..15 over 15 periods, then motor_out[0] constantly 1, motor_out[1]=0.
REQ-034 RUN at duty 8, dir_cmd0 -> 1 -> duty ramps 8..0, one all-low period, then motor_out[1] pulses at 8/15 after re-ramp; legs never both high.
REQ-035 RUN at duty 10, oc_set0 pulse -> motor_out[1:0]=0 and fault[0]=1 next cycle; channel 1 unaffected.
REQ-036 FAULT, oc_clr0=1 for 1 period then oc_set0 pulse, then oc_clr0 held -> fault[0] clears only after 2 further clean period_starts.
REQ-037 RST_N low mid-RAMP at duty 5 -> all outputs 0 immediately (asynchronous); after release channel restarts from duty_act=0.
REQ-038 duty_cmd=0 with enable=1 -> RAMP settles to RUN at 0; motor_out stays 0, no fault.

Source files
------------

// File: rtl/motor_ctrl.sv
// Multi-channel H-bridge PWM controller: shared prescaler/period counter,
// per-channel slew-limited duty FSM with dead period on reversal and latched overcurrent fault.

module motor_ch #(
    parameter int DUTY_W  = 7,
    parameter int OC_HOLD = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wrap_i,
    input  logic [DUTY_W-1:0] pwm_cnt_i,
    input  logic [DUTY_W-1:0] duty_cmd_i,
    input  logic              dir_cmd_i,
    input  logic              enable_i,
    input  logic              oc_set_i,
    input  logic              oc_clr_i,
    output logic [1:0]        leg_o,
    output logic              fault_o
);
    localparam int HOLD_W = $clog2(OC_HOLD + 1);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RAMP  = 3'd1;
    localparam logic [2:0] S_RUN   = 3'd2;
    localparam logic [2:0] S_RDN   = 3'd3;
    localparam logic [2:0] S_DEAD  = 3'd4;
    localparam logic [2:0] S_FAULT = 3'd5;

    logic [2:0]        st_q, st_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic              dir_q, dir_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [1:0]        leg_q, leg_d;
    logic [DUTY_W-1:0] slew;
    logic              abort;
    logic              level;

    always_comb begin
        slew = duty_q;
        if (duty_q < duty_cmd_i)
            slew = duty_q + DUTY_W'(1);
        else if (duty_q > duty_cmd_i)
            slew = duty_q - DUTY_W'(1);
    end

    assign abort = !enable_i || (dir_cmd_i != dir_q);

    // Everything except the overcurrent trip waits for the period boundary.
    always_comb begin
        st_d   = st_q;
        duty_d = duty_q;
        dir_d  = dir_q;
        hold_d = hold_q;
        if (oc_set_i) begin
            st_d   = S_FAULT;
            duty_d = '0;
            hold_d = '0;
        end else if (wrap_i) begin
            case (st_q)
                S_IDLE: begin
                    duty_d = '0;
                    if (enable_i) begin
                        dir_d = dir_cmd_i;
                        st_d  = S_RAMP;
                    end
                end
                S_RAMP, S_RUN: begin
                    if (abort) begin
                        if (duty_q <= DUTY_W'(1)) begin
                            duty_d = '0;
                            st_d   = S_DEAD;
                        end else begin
                            duty_d = duty_q - DUTY_W'(1);
                            st_d   = S_RDN;
                        end
                    end else begin
                        duty_d = slew;
                        if (st_q == S_RAMP && slew == duty_cmd_i)
                            st_d = S_RUN;
                    end
                end
                S_RDN: begin
                    if (duty_q <= DUTY_W'(1)) begin
                        duty_d = '0;
                        st_d   = S_DEAD;
                    end else begin
                        duty_d = duty_q - DUTY_W'(1);
                    end
                end
                S_DEAD: st_d = S_IDLE;
                S_FAULT: begin
                    if (oc_clr_i) begin
                        if (hold_q == HOLD_W'(OC_HOLD - 1)) begin
                            st_d   = S_IDLE;
                            hold_d = '0;
                        end else begin
                            hold_d = hold_q + HOLD_W'(1);
                        end
                    end else begin
                        hold_d = '0;
                    end
                end
                default: begin
                    st_d   = S_IDLE;
                    duty_d = '0;
                end
            endcase
        end
    end

    // dir_q only moves while duty is zero, so the legs can never overlap.
    assign level = pwm_cnt_i < duty_q;
    assign leg_d = {level & dir_q, level & ~dir_q} & {2{~oc_set_i}};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_q   <= S_IDLE;
            duty_q <= '0;
            dir_q  <= 1'b0;
            hold_q <= '0;
            leg_q  <= 2'b00;
        end else begin
            st_q   <= st_d;
            duty_q <= duty_d;
            dir_q  <= dir_d;
            hold_q <= hold_d;
            leg_q  <= leg_d;
        end
    end

    assign leg_o   = leg_q;
    assign fault_o = (st_q == S_FAULT);
endmodule

module motor_ctrl #(
    parameter int N_CH     = 2,
    parameter int DUTY_W   = 7,
    parameter int PRESCALE = 1000,
    parameter int OC_HOLD  = 4
) (
    input  logic                     CLK_100MHz,
    input  logic                     RST_N,
    input  logic [N_CH*DUTY_W-1:0]   duty_cmd,
    input  logic [N_CH-1:0]          dir_cmd,
    input  logic [N_CH-1:0]          enable,
    input  logic [N_CH-1:0]          oc_set,
    input  logic [N_CH-1:0]          oc_clr,
    output logic [2*N_CH-1:0]        motor_out,
    output logic [N_CH-1:0]          fault,
    output logic                     period_start
);
    localparam int MAX   = (1 << DUTY_W) - 1;
    localparam int PSC_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic [PSC_W-1:0]  psc_q, psc_d;
    logic [DUTY_W-1:0] cnt_q, cnt_d;
    logic              ps_q;
    logic              step;
    logic              wrap;

    assign step  = (psc_q == PSC_W'(PRESCALE - 1));
    assign wrap  = step && (cnt_q == DUTY_W'(MAX - 1));
    assign psc_d = step ? '0 : psc_q + PSC_W'(1);

    always_comb begin
        cnt_d = cnt_q;
        if (wrap)
            cnt_d = '0;
        else if (step)
            cnt_d = cnt_q + DUTY_W'(1);
    end

    always_ff @(posedge CLK_100MHz or negedge RST_N) begin
        if (!RST_N) begin
            psc_q <= '0;
            cnt_q <= '0;
            ps_q  <= 1'b0;
        end else begin
            psc_q <= psc_d;
            cnt_q <= cnt_d;
            ps_q  <= wrap;
        end
    end

    assign period_start = ps_q;

    for (genvar i = 0; i < N_CH; i++) begin : g_ch
        motor_ch #(
            .DUTY_W (DUTY_W),
            .OC_HOLD(OC_HOLD)
        ) u_ch (
            .clk       (CLK_100MHz),
            .rst_n     (RST_N),
            .wrap_i    (wrap),
            .pwm_cnt_i (cnt_q),
            .duty_cmd_i(duty_cmd[i*DUTY_W +: DUTY_W]),
            .dir_cmd_i (dir_cmd[i]),
            .enable_i  (enable[i]),
            .oc_set_i  (oc_set[i]),
            .oc_clr_i  (oc_clr[i]),
            .leg_o     (motor_out[2*i +: 2]),
            .fault_o   (fault[i])
        );
    end
endmodule

// File: tb/tb_motor_ctrl.sv
// Self-checking bench for motor_ctrl: directed scenarios plus random traffic,
// all compared cycle by cycle against a period-level behavioural model.

module tb_motor_ctrl;
    localparam int N_CH = 2, DUTY_W = 4, PRESCALE = 2, OC_HOLD = 2;
    localparam int MAX = 15;
    localparam int PER = PRESCALE * MAX;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH*DUTY_W-1:0] duty_cmd;
    logic [N_CH-1:0]        dir_cmd, enable, oc_set, oc_clr;
    logic [2*N_CH-1:0]      motor_out;
    logic [N_CH-1:0]        fault;
    logic                   period_start;

    always #5 clk = ~clk;

    motor_ctrl #(.N_CH(N_CH), .DUTY_W(DUTY_W), .PRESCALE(PRESCALE), .OC_HOLD(OC_HOLD)) dut (
        .CLK_100MHz(clk), .RST_N(rst_n), .duty_cmd(duty_cmd), .dir_cmd(dir_cmd),
        .enable(enable), .oc_set(oc_set), .oc_clr(oc_clr), .motor_out(motor_out),
        .fault(fault), .period_start(period_start)
    );

    typedef enum int {M_IDLE, M_RAMP, M_RUN, M_DOWN, M_DEAD, M_FAULT} mode_t;
    int                m_tick, m_pos;
    mode_t             m_mode [N_CH];
    int                m_duty [N_CH];
    bit                m_dir  [N_CH];
    int                m_clean[N_CH];
    logic [2*N_CH-1:0] m_out;
    logic [N_CH-1:0]   m_fault;
    logic              m_ps;
    int                vectors = 0, miscompares = 0;

    function automatic int cmd(int ch);
        return int'(duty_cmd[ch*DUTY_W +: DUTY_W]);
    endfunction

    task automatic model_reset();
        m_tick = 0; m_pos = 0; m_out = '0; m_fault = '0; m_ps = 1'b0;
        for (int c = 0; c < N_CH; c++) begin
            m_mode[c] = M_IDLE; m_duty[c] = 0; m_dir[c] = 1'b0; m_clean[c] = 0;
        end
    endtask

    // One clock edge of the reference: pins reflect the state before the edge.
    task automatic model_edge();
        bit boundary;
        bit on;
        boundary = (m_tick == PRESCALE - 1) && (m_pos == MAX - 1);
        m_ps = boundary;
        for (int c = 0; c < N_CH; c++) begin
            on = (m_pos < m_duty[c]) && !oc_set[c];
            m_out[2*c]   = on && !m_dir[c];
            m_out[2*c+1] = on && m_dir[c];
            if (oc_set[c]) begin
                m_mode[c] = M_FAULT; m_duty[c] = 0; m_clean[c] = 0;
            end else if (boundary) begin
                case (m_mode[c])
                    M_IDLE: if (enable[c]) begin m_dir[c] = dir_cmd[c]; m_mode[c] = M_RAMP; end
                    M_RAMP, M_RUN: begin
                        if (!enable[c] || dir_cmd[c] != m_dir[c]) begin
                            m_duty[c] = (m_duty[c] > 0) ? m_duty[c] - 1 : 0;
                            m_mode[c] = (m_duty[c] == 0) ? M_DEAD : M_DOWN;
                        end else begin
                            if (cmd(c) > m_duty[c]) m_duty[c]++;
                            else if (cmd(c) < m_duty[c]) m_duty[c]--;
                            if (m_mode[c] == M_RAMP && m_duty[c] == cmd(c)) m_mode[c] = M_RUN;
                        end
                    end
                    M_DOWN: begin
                        m_duty[c] = (m_duty[c] > 0) ? m_duty[c] - 1 : 0;
                        if (m_duty[c] == 0) m_mode[c] = M_DEAD;
                    end
                    M_DEAD: m_mode[c] = M_IDLE;
                    M_FAULT: begin
                        m_clean[c] = oc_clr[c] ? m_clean[c] + 1 : 0;
                        if (m_clean[c] == OC_HOLD) begin m_mode[c] = M_IDLE; m_clean[c] = 0; end
                    end
                    default: m_mode[c] = M_IDLE;
                endcase
            end
            m_fault[c] = (m_mode[c] == M_FAULT);
        end
        if (m_tick == PRESCALE - 1) begin
            m_tick = 0;
            m_pos = (m_pos + 1) % MAX;
        end else begin
            m_tick++;
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; duty_cmd = '0; dir_cmd = '0; enable = '0; oc_set = '0; oc_clr = '0;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            vectors++;
            if ({motor_out, fault, period_start} !== 7'b0) begin
                miscompares++;
                $display("FAIL reset_hold got %b required 0", {motor_out, fault, period_start});
            end
        end
        rst_n = 1'b1;
        repeat (2 * PER + 10) begin
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps}) begin
                miscompares++;
                $display("FAIL reset_run t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
    endtask

    task automatic test_ramp_up();
        int hi0, hi1;
        duty_cmd[0 +: DUTY_W] = DUTY_W'(15); dir_cmd[0] = 1'b0; enable[0] = 1'b1;
        repeat (18 * PER) begin
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps}) begin
                miscompares++;
                $display("FAIL ramp_up t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
        hi0 = 0; hi1 = 0;
        repeat (PER) begin
            cyc();
            hi0 += int'(motor_out[0]); hi1 += int'(motor_out[1]);
        end
        vectors++;
        if (hi0 != PER || hi1 != 0) begin
            miscompares++;
            $display("FAIL ramp_full fwd_high=%0d rev_high=%0d required %0d/0", hi0, hi1, PER);
        end
    endtask

    task automatic test_reverse();
        int hi0, hi1;
        duty_cmd[0 +: DUTY_W] = DUTY_W'(8);
        repeat (9 * PER) begin
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps}) begin
                miscompares++;
                $display("FAIL slew_down t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
        dir_cmd[0] = 1'b1;
        repeat (22 * PER) begin
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps} || motor_out[1:0] === 2'b11) begin
                miscompares++;
                $display("FAIL reverse t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
        hi0 = 0; hi1 = 0;
        repeat (PER) begin
            cyc();
            hi0 += int'(motor_out[0]); hi1 += int'(motor_out[1]);
        end
        vectors++;
        if (hi1 != 8 * PRESCALE || hi0 != 0) begin
            miscompares++;
            $display("FAIL reverse_duty rev_high=%0d fwd_high=%0d required %0d/0", hi1, hi0, 8 * PRESCALE);
        end
    endtask

    task automatic test_fault();
        int hi2;
        duty_cmd[0 +: DUTY_W] = DUTY_W'(10);
        duty_cmd[DUTY_W +: DUTY_W] = DUTY_W'(6); dir_cmd[1] = 1'b0; enable[1] = 1'b1;
        repeat (10 * PER + 7) begin
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps}) begin
                miscompares++;
                $display("FAIL pre_fault t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
        oc_set[0] = 1'b1;
        cyc();
        oc_set[0] = 1'b0;
        vectors++;
        if (motor_out[1:0] !== 2'b00 || fault !== 2'b01) begin
            miscompares++;
            $display("FAIL fault_trip legs=%b fault=%b required 00/01", motor_out[1:0], fault);
        end
        hi2 = 0;
        repeat (3 * PER) begin
            cyc(); vectors++;
            hi2 += int'(motor_out[2]);
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps}) begin
                miscompares++;
                $display("FAIL in_fault t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
        vectors++;
        if (hi2 != 3 * 6 * PRESCALE) begin
            miscompares++;
            $display("FAIL ch1_independent high=%0d required %0d", hi2, 3 * 6 * PRESCALE);
        end
    endtask

    task automatic test_fault_exit();
        int seen;
        bit got;
        oc_clr[0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 2 * PER && !got; k++) begin
            cyc(); vectors++;
            got = period_start;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps}) begin
                miscompares++;
                $display("FAIL clr_wait t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
        oc_set[0] = 1'b1;
        cyc();
        oc_set[0] = 1'b0;
        seen = 0;
        for (int k = 0; k < 4 * PER && seen < 2; k++) begin
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps}) begin
                miscompares++;
                $display("FAIL clr_hold t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
            if (period_start === 1'b1) begin
                seen++;
                vectors++;
                if (fault[0] !== (seen == 1)) begin
                    miscompares++;
                    $display("FAIL fault_release boundary=%0d fault=%b required %b", seen, fault[0], seen == 1);
                end
            end
        end
        vectors++;
        if (seen != 2) begin
            miscompares++;
            $display("FAIL fault_release_timeout boundaries=%0d required 2", seen);
        end
    endtask

    task automatic test_reset_mid_ramp();
        bit hit;
        duty_cmd[0 +: DUTY_W] = DUTY_W'(15);
        hit = 1'b0;
        for (int k = 0; k < 20 * PER && !hit; k++) begin
            cyc(); vectors++;
            hit = (m_mode[0] == M_RAMP) && (m_duty[0] == 5);
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps}) begin
                miscompares++;
                $display("FAIL ramp_to5 t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
        repeat (PER / 2) cyc();
        vectors++;
        if (!hit) begin
            miscompares++;
            $display("FAIL ramp_to5_timeout reached=0 required 1");
        end
        #2 rst_n = 1'b0;
        #1 vectors++;
        if ({motor_out, fault, period_start} !== 7'b0) begin
            miscompares++;
            $display("FAIL async_reset got %b required 0", {motor_out, fault, period_start});
        end
        model_reset();
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 3 * PER; k++) begin
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps} ||
                (k <= PER && motor_out[1:0] !== 2'b00)) begin
                miscompares++;
                $display("FAIL post_reset t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
    endtask

    task automatic test_zero_duty();
        enable = '0;
        repeat (20 * PER) cyc();
        duty_cmd[0 +: DUTY_W] = '0; enable[0] = 1'b1;
        repeat (5 * PER) begin
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps} ||
                motor_out[1:0] !== 2'b00 || fault[0] !== 1'b0) begin
                miscompares++;
                $display("FAIL zero_duty t=%0t got %b exp %b", $time, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
        vectors++;
        if (m_mode[0] != M_RUN) begin
            miscompares++;
            $display("FAIL zero_duty_mode model=%0d required RUN", m_mode[0]);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 59) == 0)  enable   = N_CH'($urandom);
            if ($urandom_range(0, 79) == 0)  duty_cmd = (N_CH*DUTY_W)'($urandom);
            if ($urandom_range(0, 149) == 0) dir_cmd  = N_CH'($urandom);
            for (int c = 0; c < N_CH; c++) begin
                oc_set[c] = ($urandom_range(0, 399) == 0);
                oc_clr[c] = ($urandom_range(0, 9) != 0);
            end
            cyc(); vectors++;
            if ({motor_out, fault, period_start} !== {m_out, m_fault, m_ps} ||
                motor_out[1:0] === 2'b11 || motor_out[3:2] === 2'b11) begin
                miscompares++;
                $display("FAIL random k=%0d got %b exp %b", k, {motor_out, fault, period_start}, {m_out, m_fault, m_ps});
            end
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at t=%0t", $time);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_ramp_up();
        test_reverse();
        test_fault();
        test_fault_exit();
        test_reset_mid_ramp();
        test_zero_duty();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
